// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: feeds bytes MSB-first into a ccff chain of CHAIN_LEN bits.
// Optional trailing CRC-8 check is compiled in with `define CCFF_CRC_EN.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W = 16
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  output logic       busy,
  output logic       done,
  output logic       crc_err
);
`ifdef CCFF_CRC_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, DONE} state_t;
  localparam state_t END_ST = CHECK;
  logic [7:0] r_crc;
  logic       r_crc_err;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam state_t END_ST = DONE;
`endif
  state_t           r_state;
  logic [7:0]       r_sh;
  logic [2:0]       r_bit;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  assign w_last        = r_cnt == CNT_W'(CHAIN_LEN - 1);
  assign ccff_shift_en = r_state == SHIFT;
  assign ccff_head     = ccff_shift_en & r_sh[7];
  assign busy          = r_state != IDLE && r_state != DONE;
  assign done          = r_state == DONE;
`ifdef CCFF_CRC_EN
  assign cfg_ready = r_state == LOAD || r_state == CHECK;
  assign crc_err   = r_crc_err;
`else
  assign cfg_ready = r_state == LOAD;
  assign crc_err   = 1'b0;
`endif
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
`ifdef CCFF_CRC_EN
      r_crc     <= '0;
      r_crc_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state <= LOAD;
          r_cnt   <= '0;
`ifdef CCFF_CRC_EN
          r_crc     <= '0;
          r_crc_err <= 1'b0;
`endif
        end
        LOAD: if (cfg_valid) begin
          r_sh    <= cfg_data;
          r_bit   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_sh  <= {r_sh[6:0], 1'b0};
          r_bit <= r_bit + 3'd1;
          r_cnt <= r_cnt + CNT_W'(1);
`ifdef CCFF_CRC_EN
          r_crc <= {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ r_sh[7]) ? 8'h07 : 8'h00);
`endif
          // a partial final byte ends early; its remaining low bits are dropped
          if (w_last) r_state <= END_ST;
          else if (r_bit == 3'd7) r_state <= LOAD;
        end
`ifdef CCFF_CRC_EN
        CHECK: if (cfg_valid) begin
          r_crc_err <= cfg_data != r_crc;
          r_state   <= DONE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: scoreboard bench for 16- and 10-bit chain loaders.
module tb_ccff_bitstream_loader;
  logic clk = 0, rst = 1, start = 0, valid = 0;
  logic [7:0] data = 0;
  logic rdy16, head16, sen16, busy16, done16, cerr16;
  logic rdy10, head10, sen10, busy10, done10, cerr10;
  int checks = 0, errors = 0;
  bit q16[$], q10[$];
  int n16 = 0, n10 = 0, tgt = 0;
  bit en16 = 1, en10 = 0;
  logic [15:0] cap16 = 0, cap10 = 0;
  int mk[2];
  logic [7:0] mc[2];
  logic w_rdy, w_done;
  assign w_rdy  = tgt ? rdy10 : rdy16;
  assign w_done = tgt ? done10 : done16;

  ccff_bitstream_loader #(.CHAIN_LEN(16), .CNT_W(16)) u16 (
    .prog_clk(clk), .prog_reset(rst), .start(start), .cfg_data(data), .cfg_valid(valid),
    .cfg_ready(rdy16), .ccff_head(head16), .ccff_shift_en(sen16), .busy(busy16),
    .done(done16), .crc_err(cerr16));
  ccff_bitstream_loader #(.CHAIN_LEN(10), .CNT_W(16)) u10 (
    .prog_clk(clk), .prog_reset(rst), .start(start), .cfg_data(data), .cfg_valid(valid),
    .cfg_ready(rdy10), .ccff_head(head10), .ccff_shift_en(sen10), .busy(busy10),
    .done(done10), .crc_err(cerr10));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sen16) begin
      n16++;
      cap16 = {cap16[14:0], head16};
      if (en16) begin
        if (q16.size() == 0) chk("extra_shift16", sen16, 0);
        else chk("head16", head16, q16.pop_front());
      end
    end
    if (sen10) begin
      n10++;
      cap10 = {cap10[14:0], head10};
      if (en10) begin
        if (q10.size() == 0) chk("extra_shift10", sen10, 0);
        else chk("head10", head10, q10.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int len = tgt ? 10 : 16;
    int nb = (len - mk[tgt] < 8) ? len - mk[tgt] : 8;
    for (int i = 0; i < nb; i++) begin
      if (tgt) q10.push_back(b[7-i]); else q16.push_back(b[7-i]);
      mc[tgt] = {mc[tgt][6:0], 1'b0} ^ ((mc[tgt][7] ^ b[7-i]) ? 8'h07 : 8'h00);
    end
    mk[tgt] += nb;
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    valid = 1;
    for (int i = 0; i < 40 && !w_rdy; i++) step();
    chk("ready_timeout", w_rdy, 1);
    if (w_rdy) push(b);
    step();
    valid = 0;
  endtask

  task automatic trailer();
`ifdef CCFF_CRC_EN
    send(mc[tgt]);
`endif
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !w_done; i++) step();
    chk("done_timeout", w_done, 1);
  endtask

  task automatic begin_load();
    start = 1;
    step();
    start = 0;
    mk[tgt] = 0;
    mc[tgt] = 0;
    chk("busy_after_start", tgt ? busy10 : busy16, 1);
  endtask

  task automatic chk_idle16(input string tag);
    chk({tag, "_ready"}, rdy16, 0);
    chk({tag, "_head"}, head16, 0);
    chk({tag, "_shift_en"}, sen16, 0);
    chk({tag, "_busy"}, busy16, 0);
    chk({tag, "_done"}, done16, 0);
    chk({tag, "_crc_err"}, cerr16, 0);
  endtask

  initial begin
    step();
    step();
    chk_idle16("reset");
    chk("reset_ready10", rdy10, 0);
    chk("reset_busy10", busy10, 0);
    rst = 0;
    step();
    chk("idle_ready", rdy16, 0);
    // back-to-back bytes into the 16-bit chain
    n16 = 0;
    begin_load();
    chk("load_ready", rdy16, 1);
    send(8'hA5);
    send(8'h3C);
    trailer();
    wait_done();
    chk("a_pattern", cap16, 16'hA53C);
    chk("a_nshift", n16, 16);
    chk("a_busy", busy16, 0);
    chk("a_crc_err", cerr16, 0);
    chk("a_ready_done", rdy16, 0);
    chk("a_queue", q16.size(), 0);
    // restart from DONE, start pulsed mid-shift, 5-cycle valid gap in LOAD
    n16 = 0;
    begin_load();
    send(8'hA5);
    start = 1;
    step();
    start = 0;
    chk("b_busy_ignored_start", busy16, 1);
    repeat (7) step();
    chk("b_gap_shift_en", sen16, 0);
    chk("b_gap_ready", rdy16, 1);
    repeat (4) step();
    chk("b_gap_count", n16, 8);
    send(8'h3C);
    trailer();
    wait_done();
    chk("b_pattern", cap16, 16'hA53C);
    chk("b_nshift", n16, 16);
    // reset after five shifted bits, then a clean reload
    n16 = 0;
    begin_load();
    send(8'hA5);
    repeat (4) step();
    rst = 1;
    step();
    chk_idle16("midrst");
    chk("midrst_nshift", n16, 5);
    rst = 0;
    q16.delete();
    n16 = 0;
    begin_load();
    send(8'hA5);
    send(8'h3C);
    trailer();
    wait_done();
    chk("c_pattern", cap16, 16'hA53C);
    chk("c_nshift", n16, 16);
    // 10-bit chain with a partial final byte
    rst = 1;
    step();
    rst = 0;
    q10.delete();
    en16 = 0;
    en10 = 1;
    tgt = 1;
    n10 = 0;
    begin_load();
    send(8'hFF);
    send(8'hC0);
    trailer();
    wait_done();
    chk("d_nshift", n10, 10);
    chk("d_pattern", cap10[9:0], 10'h3FF);
    data = 8'h55;
    valid = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("d_no_third_byte", rdy10, 0);
    end
    valid = 0;
    chk("d_nshift_after", n10, 10);
    chk("d_done_hold", done10, 1);
`ifdef CCFF_CRC_EN
    rst = 1;
    step();
    rst = 0;
    q16.delete();
    en16 = 1;
    en10 = 0;
    tgt = 0;
    begin_load();
    send(8'hA5);
    send(8'h3C);
    send(8'hEC);
    wait_done();
    chk("e_crc_err", cerr16, 1);
    step();
    chk("e_crc_err_hold", cerr16, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccff_bitstream_loader.md
CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16, number of configuration bits in the downstream ccff chain (1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, bit-counter width, at least clog2(CHAIN_LEN+1).
REQ-003 SHALL have port prog_clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port prog_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle pulse that begins a load.
REQ-006 SHALL have port cfg_data, input, 8, bitstream byte, MSB shifted first.
REQ-007 SHALL have port cfg_valid, input, 1, cfg_data valid.
REQ-008 SHALL have port cfg_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port ccff_head, output, 1, serial bit into the tile chain ccff_head.
REQ-010 SHALL have port ccff_shift_en, output, 1, prog_clk gate enable; high exactly on cycles where ccff_head is a valid chain bit.
REQ-011 SHALL have port busy, output, 1, high from accepted start until DONE.
REQ-012 SHALL have port done, output, 1, high in DONE.
REQ-013 SHALL have port crc_err, output, 1, CRC mismatch flag (tied 0 when the feature is out).

Function
REQ-014 SHALL use a state machine with states IDLE, LOAD, SHIFT, CHECK, DONE.
REQ-015 SHALL move IDLE->LOAD, or DONE->LOAD, on start; the bit counter and CRC clear on that edge; start in LOAD/SHIFT/CHECK is ignored.
REQ-016 SHALL drive cfg_ready=1 only in LOAD and CHECK; a byte transfers on the edge where cfg_valid&cfg_ready.
REQ-017 SHALL, on a LOAD transfer, latch the byte and enter SHIFT the next cycle.
REQ-018 SHALL, in SHIFT, present one bit per cycle on ccff_head (bit7 first) with ccff_shift_en=1 and increment the bit counter.
REQ-019 SHALL shift min(8, CHAIN_LEN - count) bits per byte; unused low bits of a partial final byte are discarded.
REQ-020 SHALL return SHIFT->LOAD after the eighth bit if count<CHAIN_LEN; LOAD throughput is one byte per 9 cycles with no gaps on cfg_valid.
REQ-021 SHALL, when count reaches CHAIN_LEN, go to CHECK if CCFF_CRC_EN is defined, else to DONE.
REQ-022 SHALL hold ccff_shift_en=0 and ccff_head=0 in every state other than SHIFT; cfg_valid low in LOAD stalls with no shifting.
REQ-023 SHALL hold done=1, busy=0 in DONE until the next start; crc_err holds its value until start or reset.

Reset
REQ-024 SHALL, on prog_reset, enter IDLE with cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, crc_err=0, counter and CRC cleared.
REQ-025 SHALL let reset override all other events including start in the same cycle; a load interrupted by reset is abandoned and chain contents are undefined.

Configuration
REQ-026 SHALL, with macro CCFF_CRC_EN defined, accumulate CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection) over every shifted bit.
REQ-027 SHALL, with CCFF_CRC_EN defined, accept one trailing byte in CHECK, set crc_err=1 if it differs from the CRC, and enter DONE the next cycle either way.
REQ-028 SHALL, without CCFF_CRC_EN, omit CRC logic and the CHECK state, with crc_err constant 0.

Verification
REQ-029 SHALL cover: CHAIN_LEN=16, start, bytes 0xA5,0x3C back-to-back -> ccff_head 1010010100111100 over exactly 16 ccff_shift_en cycles, then done=1.
REQ-030 SHALL cover: CHAIN_LEN=10, bytes 0xFF,0xC0 -> exactly 10 shift cycles, all ccff_head=1, no third byte accepted.
REQ-031 SHALL cover: CHAIN_LEN=16 with cfg_valid low 5 cycles between bytes -> no ccff_shift_en during the gap, same 16-bit sequence.
REQ-032 SHALL cover: prog_reset after 5 shifted bits -> next cycle IDLE with all outputs 0; a new start reloads from bit 0.
REQ-033 SHALL cover, CCFF_CRC_EN defined: bytes 0xA5,0x3C then 0xED -> crc_err=0, done=1; trailing 0xEC -> crc_err=1, done=1.
REQ-034 SHALL cover: start pulsed during SHIFT -> ignored, load completes unchanged.
